// File: rtl/red_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : red_seq_ctrl
// Brief  : Fetches N (rs, rt) word pairs, feeds each to the RED unit and
//          accumulates the 16-bit results with sticky signed overflow.
// Rev    : 1.0  initial release
// ============================================================================
module red_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic              overflow,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       red_rs,
    output logic [15:0]       red_rt,
    input  logic [15:0]       red_rd
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        ACC  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_cnt;
    logic [15:0]       r_acc;
    logic [15:0]       r_rs;
    logic [15:0]       r_rt;

    logic [15:0]       w_sum;
    logic              w_ovf;

    assign w_sum = r_acc + red_rd;
    // Signed overflow: equal-sign operands yielding a sum of the other sign.
    assign w_ovf = (r_acc[15] == red_rd[15]) && (w_sum[15] != r_acc[15]);

    // The pointer register is the read address, so it is stable for the
    // whole duration of a pending request.
    assign mem_addr = r_ptr;
    assign red_rs   = r_rs;
    assign red_rt   = r_rt;

    // Busy/done/mem_req are registered alongside each state transition so
    // they always match the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            r_ptr   <= base_addr;
                            r_cnt   <= len;
                            mem_req <= 1'b1;
                            r_state <= RD_A;
                        end else begin
                            result  <= '0;
                            done    <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                RD_A: begin
                    if (mem_valid) begin
                        r_rs    <= mem_rdata;
                        r_ptr   <= r_ptr + 1'b1;
                        r_state <= RD_B;
                    end
                end
                RD_B: begin
                    if (mem_valid) begin
                        r_rt    <= mem_rdata;
                        r_ptr   <= r_ptr + 1'b1;
                        mem_req <= 1'b0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_acc    <= w_sum;
                    overflow <= overflow | w_ovf;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        result  <= w_sum;
                        done    <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        mem_req <= 1'b1;
                        r_state <= RD_A;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_red_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_red_seq_ctrl
// Brief  : Directed bench for red_seq_ctrl with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_red_seq_ctrl;

    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, overflow, mem_req;
    logic          mem_valid = 1'b0;
    logic [15:0]   result, red_rs, red_rt, red_rd;
    logic [15:0]   mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    red_seq_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .red_rs(red_rs), .red_rt(red_rt), .red_rd(red_rd)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    // ---------------- RED stub: signed byte sum or a fixed constant --------
    int          red_mode  = 0;
    logic [15:0] red_const = '0;

    function automatic logic [15:0] bytesum(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a[7:0])) + int'($signed(a[15:8]))
          + int'($signed(b[7:0])) + int'($signed(b[15:8]));
        return 16'(s);
    endfunction

    assign red_rd = (red_mode == 1) ? red_const : bytesum(red_rs, red_rt);

    // ---------------- memory responder ------------------------------------
    logic [15:0] mem [256];
    int          wait_n   = 0;
    int          wcnt     = 0;
    bit          spurious = 1'b0;
    bit          r_hs;

    always @(posedge clk) begin
        cyc++;
        r_hs = mem_req && mem_valid;
        #1;
        if (r_hs || !mem_req) wcnt = 0;
        if (mem_req && wcnt >= wait_n) begin
            mem_valid = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            if (mem_req) wcnt++;
            mem_valid = spurious;
            mem_rdata = 16'hDEAD;
        end
    end

    // ---------------- transaction model ------------------------------------
    bit          m_act    = 1'b0;
    int          t_s      = 0;
    int          t_done   = 0;
    int          pend_len = 0;
    logic [15:0] pend_res = '0, pend_rs = '0, pend_rt = '0;
    bit          pend_ovf = 1'b0;
    logic [15:0] cur_res  = '0;
    bit          cur_ovf  = 1'b0;
    logic [7:0]  aq[$];
    int          done_cyc = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        bit inwin;
        inwin = m_act && cyc >= t_s && cyc <= t_done;
        if (m_act && cyc == t_done) begin
            cur_res = pend_res;
            cur_ovf = pend_ovf;
        end
        chk("busy", busy, inwin);
        chk("done", done, m_act && cyc == t_done);
        chk("result", result, cur_res);
        if (!inwin || cyc == t_done) begin
            chk("overflow", overflow, cur_ovf);
            chk("mem_req_quiet", mem_req, 1'b0);
        end
        if (mem_req) begin
            if (aq.size() == 0) begin
                chk("unexpected_read", 1, 0);
            end else begin
                chk("mem_addr", mem_addr, aq[0]);
                if (mem_valid) void'(aq.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("reads_left_at_done", aq.size(), 0);
            if (pend_len > 0) begin
                chk("red_rs_at_done", red_rs, pend_rs);
                chk("red_rt_at_done", red_rt, pend_rt);
            end
        end
    end

    // Builds the expected outcome from memory contents and the RED stub,
    // then issues a one-cycle start pulse.
    task automatic launch(input logic [7:0] b, input logic [7:0] n, input int w);
        int          acc;
        bit          ov;
        logic [7:0]  a;
        logic [15:0] rs, rt, r;
        @(negedge clk);
        wait_n = w;
        acc = 0; ov = 1'b0; a = b;
        aq.delete();
        for (int i = 0; i < int'(n); i++) begin
            rs = mem[a]; aq.push_back(a); a = a + 8'd1;
            rt = mem[a]; aq.push_back(a); a = a + 8'd1;
            r = (red_mode == 1) ? red_const : bytesum(rs, rt);
            acc = acc + int'($signed(r));
            if (acc > 32767)  begin ov = 1'b1; acc = acc - 65536; end
            if (acc < -32768) begin ov = 1'b1; acc = acc + 65536; end
            pend_rs = rs; pend_rt = rt;
        end
        pend_res = 16'(acc);
        pend_ovf = ov;
        pend_len = int'(n);
        t_s      = cyc + 1;
        t_done   = t_s + int'(n) * (2 * w + 3);
        m_act    = 1'b1;
        base_addr = b; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op();
        while (cyc <= t_done) @(negedge clk);
        @(negedge clk);
    endtask

    function automatic int lat();
        return done_cyc - (t_s - 1);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37 + 5);
        for (int i = 16'h10; i <= 16'h11; i++) mem[i] = 16'h0101;
        for (int i = 16'h20; i <= 16'h25; i++) mem[i] = 16'h0101;
        mem[8'hFF] = 16'h0101;
        mem[8'h00] = 16'h0101;
        mem[8'h40] = 16'h0202;
        mem[8'h41] = 16'h0303;

        #1 rst_n = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_red_rs", red_rs, 0);
        chk("rst_red_rt", red_rt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single pair, zero-wait
        launch(8'h10, 8'd1, 0); finish_op();
        chk("t1_result", result, 16'h0004);
        chk("t1_latency", lat(), 4);
        chk("t1_overflow", overflow, 0);
        chk("t1_red_rs", red_rs, 16'h0101);

        // 2: three pairs
        d = done_cnt;
        launch(8'h20, 8'd3, 0); finish_op();
        chk("t2_result", result, 16'h000C);
        chk("t2_latency", lat(), 10);
        chk("t2_done_pulses", done_cnt - d, 1);

        // 3: two wait states on every read
        launch(8'h10, 8'd1, 2); finish_op();
        chk("t3_result", result, 16'h0004);
        chk("t3_latency", lat(), 8);

        // 4: overflow, then a clean run clears it
        red_mode = 1; red_const = 16'h7000;
        launch(8'h50, 8'd2, 0); finish_op();
        chk("t4_result", result, 16'hE000);
        chk("t4_overflow", overflow, 1);
        red_const = 16'h0001;
        launch(8'h60, 8'd1, 0); finish_op();
        chk("t4b_result", result, 16'h0001);
        chk("t4b_overflow", overflow, 0);
        red_mode = 0;

        // 5: len=0, address wrap, start while busy with stray mem_valid
        launch(8'h33, 8'd0, 0); finish_op();
        chk("t5_len0_result", result, 16'h0000);
        chk("t5_len0_latency", lat(), 1);
        launch(8'hFF, 8'd1, 0); finish_op();
        chk("t5_wrap_result", result, 16'h0004);
        chk("t5_wrap_ptr", mem_addr, 8'h01);
        spurious = 1'b1;
        d = done_cnt;
        launch(8'h40, 8'd1, 0);
        base_addr = 8'h80; len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op();
        spurious = 1'b0;
        chk("t5_busy_result", result, 16'h000A);
        chk("t5_busy_latency", lat(), 4);
        chk("t5_busy_pulses", done_cnt - d, 1);

        // 6: reset while reading rt
        launch(8'h10, 8'd1, 0);
        @(negedge clk);
        #2;
        chk("t6_req_before_rst", mem_req, 1);
        d = done_cnt;
        rst_n = 1'b0;
        m_act = 1'b0; aq.delete(); cur_res = '0; cur_ovf = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_mem_req", mem_req, 0);
        chk("t6_result", result, 0);
        chk("t6_red_rs", red_rs, 0);
        chk("t6_mem_addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("t6_no_done", done_cnt - d, 0);
        launch(8'h10, 8'd1, 0); finish_op();
        chk("t6_after_result", result, 16'h0004);
        chk("t6_after_latency", lat(), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
